mem_ctrl_fsm: RTL and testbench
===============================

# mem_ctrl_fsm

Registered, multi-cycle successor to the combinational opcode decoder in the Aurora core's memory stage. It decodes R-type, load and store opcodes and sequences load/store accesses against a variable-latency data memory through a ready handshake. While an access is outstanding it raises a pipeline stall, and it aborts any access that exceeds a parametrised wait bound. It sits between the ID/EX pipeline register and the data-memory port; its outputs drive the memory enables and the register-file write-back control.

## Interface
- OPCODE_W, 7, opcode width
- OP_RTYPE, 7'b0110011, R-type opcode
- OP_LOAD, 7'b0000011, load opcode
- OP_STORE, 7'b0100011, store opcode
- WAIT_W, 4, wait-counter width
- MAX_WAIT, 15, maximum ACCESS cycles before abort; must satisfy 1 ≤ MAX_WAIT ≤ 2^WAIT_W − 1
- clk_i  input  1  single clock; all state changes on the rising edge
- reset_n_i  input  1  asynchronous, active-low reset
- valid_i  input  1  opcode_i holds a valid instruction this cycle
- opcode_i  input  OPCODE_W  instruction opcode
- mem_ready_i  input  1  memory has completed the current request
- mem_read_i  output  1  memory read request (registered)
- mem_write_i  output  1  memory write request (registered)
- mem_to_reg_i  output  1  select memory data for write-back (registered)
- reg_write_i  output  1  register-file write enable (registered)
- load_i  output  1  load in progress (registered)
- store_i  output  1  store in progress (registered)
- stall_i  output  1  upstream must hold its instruction (registered)
- timeout_i  output  1  one-cycle pulse when an access is aborted (registered)

## Operation
- States: IDLE, ACCESS, WB, ERR. Internal registers: wait_cnt (WAIT_W bits) and kind (load/store).
- Reset (reset_n_i low, asynchronous): state goes to IDLE, wait_cnt to 0, and every output to 0. This applies mid-access; the request is dropped without a timeout pulse.
- IDLE, valid_i=1, opcode == OP_RTYPE: stay in IDLE; next cycle reg_write_i=1, all other outputs 0.
- IDLE, valid_i=1, opcode == OP_LOAD: go to ACCESS; next cycle mem_read_i=1, load_i=1, mem_to_reg_i=1, stall_i=1; wait_cnt=0.
- IDLE, valid_i=1, opcode == OP_STORE: go to ACCESS; next cycle mem_write_i=1, store_i=1, stall_i=1; mem_to_reg_i=0; wait_cnt=0.
- IDLE, valid_i=0 or any other opcode: all outputs 0 next cycle (nop).
- ACCESS, mem_ready_i=1:
  - load: go to WB; mem_read_i=0, reg_write_i=1, mem_to_reg_i=1, load_i=1, stall_i=1.
  - store: go to IDLE; all outputs 0.
- ACCESS, mem_ready_i=0, wait_cnt < MAX_WAIT−1: wait_cnt+1; outputs held.
- ACCESS, mem_ready_i=0, wait_cnt == MAX_WAIT−1: go to ERR; timeout_i=1, stall_i=1, all other outputs 0.
- WB: go to IDLE unconditionally; all outputs 0.
- ERR: go to IDLE unconditionally; all outputs 0.
- valid_i and opcode_i are ignored outside IDLE.
- mem_ready_i is ignored outside ACCESS.
- wait_cnt never wraps.

## Timing
- Decode latency: 1 cycle from the edge sampling valid_i to the outputs asserting.
- Back-to-back R-types: reg_write_i stays high continuously; throughput is 1 per cycle.
- Load occupancy: 1 (ACCESS, minimum) + N wait cycles + 1 (WB).
  - stall_i is high from the first ACCESS cycle through WB and low in the following IDLE cycle.
  - The next instruction is sampled on the edge that leaves IDLE.
- Store occupancy: ACCESS for N+1 cycles; stall_i drops the cycle after mem_ready_i is sampled high.
- mem_read_i/mem_write_i stay high for exactly the ACCESS cycles, up to a maximum of MAX_WAIT.
- If mem_ready_i=1 on the same edge that would time out, the handshake wins: no timeout.
- timeout_i is high for exactly 1 cycle (ERR); stall_i remains high during ERR.
- All outputs are glitch-free register outputs; none is a combinational function of the inputs.

## Test plan
- Reset mid-load:
  - Stimulus: assert reset_n_i low during ACCESS.
  - Required response: all outputs 0 immediately (asynchronously); after release, state is IDLE and no timeout_i pulse occurs.
- Three consecutive valid R-types:
  - Stimulus: opcode 0110011 on three consecutive cycles.
  - Required response: reg_write_i high for 3 cycles, starting 1 cycle after the first; stall_i stays 0.
- Load with mem_ready_i high on the 3rd ACCESS cycle:
  - Required response: mem_read_i high for 3 cycles, then 1 WB cycle with reg_write_i=1 and mem_to_reg_i=1; stall_i high for 4 cycles.
- Store with mem_ready_i high on the 1st ACCESS cycle:
  - Required response: mem_write_i=1 and store_i=1 for 1 cycle; reg_write_i never asserts; stall_i high for 1 cycle.
- Load timeout (MAX_WAIT=15):
  - Stimulus: mem_ready_i held at 0.
  - Required response: mem_read_i high for exactly 15 cycles, then timeout_i=1 for 1 cycle, then IDLE with all outputs 0.
  - Variant: mem_ready_i asserted on the 15th cycle gives WB with no timeout.
- Ignored inputs:
  - Stimulus: unknown opcode 1111111 with valid_i=1; separately, a new valid store presented while a load is in ACCESS.
  - Required response: unknown opcode leaves all outputs 0; the store is ignored and no mem_write_i asserts.

Source files
------------

// File: rtl/mem_ctrl_fsm.sv
// Load/store/R-type decoder sequencing a variable-latency data memory; outputs settle 1 cycle after
// the sampling edge. Holds stall_i high while an access is outstanding; aborts after MAX_WAIT ACCESS cycles.
module mem_ctrl_fsm #(
   parameter int                  OPCODE_W = 7,
   parameter logic [OPCODE_W-1:0] OP_RTYPE = 7'b0110011,
   parameter logic [OPCODE_W-1:0] OP_LOAD  = 7'b0000011,
   parameter logic [OPCODE_W-1:0] OP_STORE = 7'b0100011,
   parameter int                  WAIT_W   = 4,
   parameter int                  MAX_WAIT = 15
) (
   input  logic                clk_i,
   input  logic                reset_n_i,
   input  logic                valid_i,
   input  logic [OPCODE_W-1:0] opcode_i,
   input  logic                mem_ready_i,
   output logic                mem_read_i,
   output logic                mem_write_i,
   output logic                mem_to_reg_i,
   output logic                reg_write_i,
   output logic                load_i,
   output logic                store_i,
   output logic                stall_i,
   output logic                timeout_i
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_WB,
      ST_ERR
   } state_t;

   localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MAX_WAIT - 1);

   if (MAX_WAIT < 1 || MAX_WAIT > (2 ** WAIT_W) - 1) begin : g_bad_max_wait
      $error("MAX_WAIT must lie in 1 .. 2**WAIT_W-1");
   end

   state_t              state_q, state_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic                kind_load_q, kind_load_d;
   logic                mem_read_q, mem_read_d;
   logic                mem_write_q, mem_write_d;
   logic                mem_to_reg_q, mem_to_reg_d;
   logic                reg_write_q, reg_write_d;
   logic                load_q, load_d;
   logic                store_q, store_d;
   logic                stall_q, stall_d;
   logic                timeout_q, timeout_d;

   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      kind_load_d  = kind_load_q;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      reg_write_d  = 1'b0;
      load_d       = 1'b0;
      store_d      = 1'b0;
      stall_d      = 1'b0;
      timeout_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (valid_i) begin
               if (opcode_i == OP_RTYPE) begin
                  reg_write_d = 1'b1;
               end else if (opcode_i == OP_LOAD) begin
                  state_d      = ST_ACCESS;
                  wait_cnt_d   = '0;
                  kind_load_d  = 1'b1;
                  mem_read_d   = 1'b1;
                  mem_to_reg_d = 1'b1;
                  load_d       = 1'b1;
                  stall_d      = 1'b1;
               end else if (opcode_i == OP_STORE) begin
                  state_d     = ST_ACCESS;
                  wait_cnt_d  = '0;
                  kind_load_d = 1'b0;
                  mem_write_d = 1'b1;
                  store_d     = 1'b1;
                  stall_d     = 1'b1;
               end
            end
         end

         ST_ACCESS: begin
            // A handshake on the last permitted cycle beats the timeout.
            if (mem_ready_i) begin
               if (kind_load_q) begin
                  state_d      = ST_WB;
                  reg_write_d  = 1'b1;
                  mem_to_reg_d = 1'b1;
                  load_d       = 1'b1;
                  stall_d      = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (wait_cnt_q == LAST_WAIT) begin
               state_d   = ST_ERR;
               timeout_d = 1'b1;
               stall_d   = 1'b1;
            end else begin
               wait_cnt_d   = wait_cnt_q + WAIT_W'(1);
               mem_read_d   = kind_load_q;
               mem_to_reg_d = kind_load_q;
               load_d       = kind_load_q;
               mem_write_d  = ~kind_load_q;
               store_d      = ~kind_load_q;
               stall_d      = 1'b1;
            end
         end

         ST_WB:   state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q      <= ST_IDLE;
         wait_cnt_q   <= '0;
         kind_load_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         reg_write_q  <= 1'b0;
         load_q       <= 1'b0;
         store_q      <= 1'b0;
         stall_q      <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         kind_load_q  <= kind_load_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         reg_write_q  <= reg_write_d;
         load_q       <= load_d;
         store_q      <= store_d;
         stall_q      <= stall_d;
         timeout_q    <= timeout_d;
      end
   end

   assign mem_read_i   = mem_read_q;
   assign mem_write_i  = mem_write_q;
   assign mem_to_reg_i = mem_to_reg_q;
   assign reg_write_i  = reg_write_q;
   assign load_i       = load_q;
   assign store_i      = store_q;
   assign stall_i      = stall_q;
   assign timeout_i    = timeout_q;

endmodule

// File: tb/tb_mem_ctrl_fsm.sv
// Bench for mem_ctrl_fsm: each instruction is expanded into its expected per-cycle output trace,
// which a single compare process checks every cycle; directed cases also pin totals with literals.
module tb_mem_ctrl_fsm;

   localparam int         MW       = 15;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   // {mem_read, mem_write, mem_to_reg, reg_write, load, store, stall, timeout}
   localparam logic [7:0] V_ACC_LD = 8'b1010_1010;
   localparam logic [7:0] V_WB     = 8'b0011_1010;
   localparam logic [7:0] V_ACC_ST = 8'b0100_0110;
   localparam logic [7:0] V_RTYPE  = 8'b0001_0000;
   localparam logic [7:0] V_ERR    = 8'b0000_0011;
   localparam logic [7:0] V_ZERO   = 8'b0000_0000;

   logic       clk_i = 1'b0;
   logic       reset_n_i;
   logic       valid_i;
   logic [6:0] opcode_i;
   logic       mem_ready_i;
   logic       mem_read_i, mem_write_i, mem_to_reg_i, reg_write_i;
   logic       load_i, store_i, stall_i, timeout_i;
   logic [7:0] dut_vec;

   int         total = 0;
   int         bad   = 0;
   logic       chk_en = 1'b0;
   logic       junk_store = 1'b0;
   logic [7:0] exp_q[$];
   int         cnt_rd, cnt_wr, cnt_rw, cnt_stall, cnt_to;

   always #5 clk_i = ~clk_i;

   mem_ctrl_fsm #(.MAX_WAIT(MW)) dut (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .valid_i      (valid_i),
      .opcode_i     (opcode_i),
      .mem_ready_i  (mem_ready_i),
      .mem_read_i   (mem_read_i),
      .mem_write_i  (mem_write_i),
      .mem_to_reg_i (mem_to_reg_i),
      .reg_write_i  (reg_write_i),
      .load_i       (load_i),
      .store_i      (store_i),
      .stall_i      (stall_i),
      .timeout_i    (timeout_i)
   );

   assign dut_vec = {mem_read_i, mem_write_i, mem_to_reg_i, reg_write_i,
                     load_i, store_i, stall_i, timeout_i};

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   always begin : compare_proc
      logic [7:0] e;
      @(posedge clk_i);
      #1;
      if (chk_en && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk($sformatf("cycle@%0t", $time), int'(dut_vec), int'(e));
         cnt_rd    += int'(mem_read_i);
         cnt_wr    += int'(mem_write_i);
         cnt_rw    += int'(reg_write_i);
         cnt_stall += int'(stall_i);
         cnt_to    += int'(timeout_i);
      end
   end

   task automatic clear_cnt();
      cnt_rd = 0; cnt_wr = 0; cnt_rw = 0; cnt_stall = 0; cnt_to = 0;
   endtask

   task automatic settle();
      @(posedge clk_i);
      #2;
   endtask

   function automatic logic [6:0] rand_other();
      logic [6:0] o;
      o = 7'($urandom);
      if (o == OP_LOAD || o == OP_STORE || o == OP_RTYPE) o = 7'h7F;
      return o;
   endfunction

   function automatic logic [6:0] rand_junk_op();
      case ($urandom_range(0, 3))
         0:       return OP_LOAD;
         1:       return OP_STORE;
         2:       return OP_RTYPE;
         default: return rand_other();
      endcase
   endfunction

   // k = ACCESS cycle on which mem_ready is offered (1..MW); k > MW means it never comes.
   task automatic drive_instr(input logic v, input logic [6:0] op, input int k);
      logic [7:0] vecs[$];
      logic       is_mem;
      logic [7:0] acc;
      int         acc_n;
      vecs   = {};
      is_mem = v && (op == OP_LOAD || op == OP_STORE);
      acc    = (op == OP_LOAD) ? V_ACC_LD : V_ACC_ST;
      acc_n  = (k <= MW) ? k : MW;
      if (is_mem) begin
         for (int j = 0; j < acc_n; j++) vecs.push_back(acc);
         if (k > MW) vecs.push_back(V_ERR);
         else if (op == OP_LOAD) vecs.push_back(V_WB);
         vecs.push_back(V_ZERO);
      end else if (v && op == OP_RTYPE) begin
         vecs.push_back(V_RTYPE);
      end else begin
         vecs.push_back(V_ZERO);
      end
      for (int c = 0; c < vecs.size(); c++) begin
         @(negedge clk_i);
         if (c == 0) begin
            valid_i     = v;
            opcode_i    = op;
            mem_ready_i = 1'($urandom);
         end else begin
            valid_i  = junk_store ? 1'b1 : 1'($urandom);
            opcode_i = junk_store ? OP_STORE : rand_junk_op();
            if (is_mem && c <= acc_n) mem_ready_i = (c == k);
            else mem_ready_i = 1'($urandom);
         end
         exp_q.push_back(vecs[c]);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      valid_i     = 1'b0;
      opcode_i    = '0;
      mem_ready_i = 1'b0;
      reset_n_i   = 1'b1;
      clear_cnt();
      #2 reset_n_i = 1'b0;
      repeat (2) @(negedge clk_i);
      chk("reset_outputs", int'(dut_vec), 0);
      reset_n_i = 1'b1;
      chk_en = 1'b1;

      clear_cnt();
      repeat (3) drive_instr(1'b1, OP_RTYPE, 1);
      drive_instr(1'b0, OP_RTYPE, 1);
      settle();
      chk("rtype3_regwrite", cnt_rw, 3);
      chk("rtype3_stall", cnt_stall, 0);

      clear_cnt();
      drive_instr(1'b1, OP_LOAD, 3);
      settle();
      chk("load3_read", cnt_rd, 3);
      chk("load3_regwrite", cnt_rw, 1);
      chk("load3_stall", cnt_stall, 4);

      clear_cnt();
      drive_instr(1'b1, OP_STORE, 1);
      settle();
      chk("store1_write", cnt_wr, 1);
      chk("store1_regwrite", cnt_rw, 0);
      chk("store1_stall", cnt_stall, 1);

      clear_cnt();
      drive_instr(1'b1, OP_LOAD, MW + 1);
      settle();
      chk("load_to_read", cnt_rd, 15);
      chk("load_to_pulse", cnt_to, 1);
      chk("load_to_stall", cnt_stall, 16);

      clear_cnt();
      drive_instr(1'b1, OP_LOAD, MW);
      settle();
      chk("load_last_read", cnt_rd, 15);
      chk("load_last_to", cnt_to, 0);
      chk("load_last_regwrite", cnt_rw, 1);

      clear_cnt();
      drive_instr(1'b1, 7'b1111111, 1);
      settle();
      chk("unknown_op_quiet", cnt_rd + cnt_wr + cnt_rw + cnt_stall + cnt_to, 0);

      clear_cnt();
      junk_store = 1'b1;
      drive_instr(1'b1, OP_LOAD, 5);
      junk_store = 1'b0;
      settle();
      chk("store_during_load", cnt_wr, 0);

      // Asynchronous reset in the middle of a load.
      chk_en = 1'b0;
      exp_q.delete();
      @(negedge clk_i);
      valid_i = 1'b1; opcode_i = OP_LOAD; mem_ready_i = 1'b0;
      @(negedge clk_i);
      valid_i = 1'b1; opcode_i = OP_STORE;
      @(negedge clk_i);
      #1 chk("mid_load", int'(dut_vec), int'(V_ACC_LD));
      #1 reset_n_i = 1'b0;
      #1 chk("async_reset", int'(dut_vec), 0);
      valid_i = 1'b0;
      @(negedge clk_i);
      chk("held_reset", int'(dut_vec), 0);
      reset_n_i = 1'b1;
      chk_en = 1'b1;
      clear_cnt();
      repeat (20) drive_instr(1'b0, OP_LOAD, 1);
      drive_instr(1'b1, OP_RTYPE, 1);
      settle();
      chk("no_timeout_after_reset", cnt_to, 0);
      chk("idle_after_reset", cnt_rw, 1);

      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 5))
            0:       drive_instr(1'b1, OP_RTYPE, 1);
            1, 2:    drive_instr(1'b1, OP_LOAD, $urandom_range(1, MW + 1));
            3:       drive_instr(1'b1, OP_STORE, $urandom_range(1, MW + 1));
            4:       drive_instr(1'b1, rand_other(), 1);
            default: drive_instr(1'b0, rand_junk_op(), 1);
         endcase
      end
      settle();
      chk("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
